// File: rtl/ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: word, word address and byte mask.
package ram_arb_pkg;
    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned MASK_W   = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] waddr_t;
    typedef logic [MASK_W-1:0] bmask_t;
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req after index 'last', wrapping.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant
);
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous word RAM among NREQ requesters,
// with per-requester lock for atomic sequences and a fixed one-cycle read response.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic   [NREQ-1:0]    req_valid,
    output logic   [NREQ-1:0]    req_ready,
    input  waddr_t [NREQ-1:0]    req_addr,
    input  word_t  [NREQ-1:0]    req_data_w,
    input  bmask_t [NREQ-1:0]    req_mask_w,
    input  logic   [NREQ-1:0]    req_lock,
    output logic   [NREQ-1:0]    rsp_valid,
    output word_t                rsp_data,
    output waddr_t               bus_addr,
    input  word_t                bus_data_r,
    output word_t                bus_data_w,
    output bmask_t               bus_mask_w
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   last_q, last_d;
    logic            lock_active_q, lock_active_d;
    logic [IW-1:0]   lock_owner_q, lock_owner_d;
    logic [NREQ-1:0] rsp_pend_q, rsp_pend_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   win_idx;
    logic            xfer;

    // While locked only the owner may compete, even when it is idle.
    always_comb begin
        eligible = req_valid;
        if (lock_active_q) begin
            eligible = req_valid & (NREQ'(1) << lock_owner_q);
        end
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req   (eligible),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        req_ready = reset ? '0 : grant;
        xfer      = |req_ready;
        win_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    // Idle bus issues a harmless read of word 0.
    always_comb begin
        bus_addr   = '0;
        bus_data_w = '0;
        bus_mask_w = '0;
        if (xfer) begin
            bus_addr   = req_addr[win_idx];
            bus_data_w = req_data_w[win_idx];
            bus_mask_w = req_mask_w[win_idx];
        end
    end

    always_comb begin
        last_d        = last_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        rsp_pend_d    = '0;
        if (lock_active_q && !req_lock[lock_owner_q]) begin
            lock_active_d = 1'b0;
        end
        if (xfer) begin
            last_d = win_idx;
            if (req_lock[win_idx]) begin
                lock_active_d = 1'b1;
                lock_owner_d  = win_idx;
            end
            if (req_mask_w[win_idx] == '0) begin
                rsp_pend_d[win_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q        <= IW'(NREQ - 1);
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
            rsp_pend_q    <= '0;
        end else begin
            last_q        <= last_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            rsp_pend_q    <= rsp_pend_d;
        end
    end

    // RAM output after a write may be X; only forward it when a read is due.
    always_comb begin
        rsp_valid = rsp_pend_q;
        rsp_data  = (|rsp_pend_q) ? bus_data_r : '0;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic             clock;
    logic             reset;
    logic   [1:0]     req_valid;
    logic   [1:0]     req_ready;
    waddr_t [1:0]     req_addr;
    word_t  [1:0]     req_data_w;
    bmask_t [1:0]     req_mask_w;
    logic   [1:0]     req_lock;
    logic   [1:0]     rsp_valid;
    word_t            rsp_data;
    waddr_t           bus_addr;
    word_t            bus_data_r;
    word_t            bus_data_w;
    bmask_t           bus_mask_w;

    int n_tests;
    int n_fail;

    word_t mem [0:255];

    ram_arbiter #(.NREQ(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data_w (req_data_w),
        .req_mask_w (req_mask_w),
        .req_lock   (req_lock),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .bus_addr   (bus_addr),
        .bus_data_r (bus_data_r),
        .bus_data_w (bus_data_w),
        .bus_mask_w (bus_mask_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: writes leave the read port undefined.
    always @(posedge clock) begin
        if (bus_mask_w == 4'b0000) begin
            bus_data_r <= mem[bus_addr[7:0]];
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus_mask_w[b]) mem[bus_addr[7:0]][8*b +: 8] <= bus_data_w[8*b +: 8];
            end
            bus_data_r <= 'x;
        end
    end

    always @(negedge clock) begin
        #2;
        n_tests++;
        if (!$onehot0(req_ready)) begin
            n_fail++;
            $display("FAIL onehot_ready: req_ready=%b required one-hot or zero", req_ready);
        end
        n_tests++;
        if (!$onehot0(rsp_valid)) begin
            n_fail++;
            $display("FAIL onehot_rsp: rsp_valid=%b required one-hot or zero", rsp_valid);
        end
    end

    task automatic idle_inputs();
        req_valid  = 2'b00;
        req_lock   = 2'b00;
        req_mask_w = '0;
        req_addr   = '0;
        req_data_w = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_valid     = 2'b11;
        req_mask_w[0] = 4'hF;
        @(negedge clock);
        #1;
        n_tests++;
        if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        n_tests++;
        if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        n_tests++;
        if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_tests++;
        if (bus_mask_w !== 4'h0) begin n_fail++; $display("FAIL reset_bus_mask: got %h want 0", bus_mask_w); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ready;
        logic [1:0] prev_ready;
        @(negedge clock);
        reset         = 1'b0;
        req_valid     = 2'b11;
        req_mask_w    = '0;
        req_addr[0]   = 30'd1;
        req_addr[1]   = 30'd2;
        prev_ready    = 2'b00;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_ready);
            end
            n_tests++;
            if (rsp_valid !== prev_ready) begin
                n_fail++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", k, rsp_valid, prev_ready);
            end
            if (k > 0) begin
                n_tests++;
                if (rsp_data !== ((prev_ready == 2'b01) ? 32'hA000_0001 : 32'hA000_0002)) begin
                    n_fail++; $display("FAIL rr_rsp_data[%0d]: got %h", k, rsp_data);
                end
            end
            prev_ready = exp_ready;
        end
    endtask

    task automatic test_write_read();
        @(negedge clock);
        idle_inputs();
        req_valid     = 2'b10;
        req_addr[1]   = 30'h10;
        req_data_w[1] = 32'hDEAD_BEEF;
        req_mask_w[1] = 4'hF;
        #1;
        n_tests++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL wr_ready: got %b want 10", req_ready); end
        n_tests++;
        if (bus_mask_w !== 4'hF || bus_addr !== 30'h10) begin
            n_fail++; $display("FAIL wr_bus: mask %h addr %h want F/10", bus_mask_w, bus_addr);
        end
        @(negedge clock);
        idle_inputs();
        req_valid   = 2'b01;
        req_addr[0] = 30'h10;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_ready: got %b want 01", req_ready); end
        n_tests++;
        if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 00", rsp_valid); end
        @(negedge clock);
        idle_inputs();
        #1;
        n_tests++;
        if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_rsp_valid: got %b want 01", rsp_valid); end
        n_tests++;
        if (rsp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rsp_data: got %h want deadbeef", rsp_data); end
    endtask

    task automatic test_partial_write();
        @(negedge clock);
        idle_inputs();
        req_valid     = 2'b10;
        req_addr[1]   = 30'h20;
        req_data_w[1] = 32'h1122_3344;
        req_mask_w[1] = 4'hF;
        @(negedge clock);
        req_data_w[1] = 32'h0000_00AA;
        req_mask_w[1] = 4'b0001;
        #1;
        n_tests++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL pw_ready: got %b want 10", req_ready); end
        n_tests++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL pw_no_rsp: valid %b data %h want 00/0", rsp_valid, rsp_data);
        end
        @(negedge clock);
        req_data_w[1] = '0;
        req_mask_w[1] = 4'b0000;
        #1;
        n_tests++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL pw_no_rsp2: valid %b data %h want 00/0", rsp_valid, rsp_data);
        end
        @(negedge clock);
        idle_inputs();
        #1;
        n_tests++;
        if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL pw_rsp_valid: got %b want 10", rsp_valid); end
        n_tests++;
        if (rsp_data !== 32'h1122_33AA) begin n_fail++; $display("FAIL pw_rsp_data: got %h want 112233aa", rsp_data); end
    endtask

    task automatic test_lock();
        logic [1:0] exp_ready [0:5];
        exp_ready = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            idle_inputs();
            req_addr[0] = 30'd1;
            req_addr[1] = 30'd2;
            case (c)
                0: req_valid = 2'b01;
                1: begin req_valid = 2'b11; req_lock = 2'b10; end
                2: begin
                    req_valid = 2'b11; req_lock = 2'b10;
                    req_addr[1] = 30'h30; req_data_w[1] = 32'h55; req_mask_w[1] = 4'hF;
                end
                3: begin req_valid = 2'b01; req_lock = 2'b10; end
                default: req_valid = 2'b01;
            endcase
            #1;
            n_tests++;
            if (req_ready !== exp_ready[c]) begin
                n_fail++; $display("FAIL lock_ready[%0d]: got %b want %b", c, req_ready, exp_ready[c]);
            end
            if (c == 2) begin
                n_tests++;
                if (rsp_valid !== 2'b10 || rsp_data !== 32'hA000_0002) begin
                    n_fail++; $display("FAIL lock_rsp: valid %b data %h want 10/a0000002", rsp_valid, rsp_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        idle_inputs();
        req_valid   = 2'b10;
        req_lock    = 2'b10;
        req_addr[1] = 30'd2;
        #1;
        n_tests++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rst_pre_ready: got %b want 10", req_ready); end
        @(negedge clock);
        reset         = 1'b1;
        req_valid     = 2'b11;
        req_lock      = 2'b00;
        req_mask_w[1] = 4'hF;
        #1;
        n_tests++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL rst_rsp: valid %b data %h want 00/0", rsp_valid, rsp_data);
        end
        n_tests++;
        if (req_ready !== 2'b00 || bus_mask_w !== 4'h0) begin
            n_fail++; $display("FAIL rst_bus: ready %b mask %h want 00/0", req_ready, bus_mask_w);
        end
        @(negedge clock);
        reset      = 1'b0;
        req_mask_w = '0;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_win: got %b want 01", req_ready); end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            idle_inputs();
            req_addr[1]   = 30'h3F;
            req_data_w[1] = 32'hFFFF_FFFF;
            req_mask_w[1] = 4'hF;
            #1;
            if (c > 0) begin
                n_tests++;
                if (bus_mask_w !== 4'h0 || bus_addr !== 30'h0 || bus_data_w !== 32'h0) begin
                    n_fail++; $display("FAIL idle_bus[%0d]: mask %h addr %h data %h want 0", c, bus_mask_w, bus_addr, bus_data_w);
                end
                n_tests++;
                if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
                    n_fail++; $display("FAIL idle_rsp[%0d]: valid %b data %h want 00/0", c, rsp_valid, rsp_data);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_write_read();
        test_partial_write();
        test_lock();
        test_reset_mid();
        test_idle();
        @(negedge clock);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
